imem: RTL and testbench

IMEM -- requirements
Module: imem

---
 rtl/imem_pkg.sv | 9 +
 rtl/imem_rom.sv | 16 +
 rtl/imem.sv | 36 +++
 tb/tb_imem.sv | 84 ++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants for the instruction memory (base address, NOP, boot program).
package imem_pkg;
  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0100_0000;
  localparam logic [31:0] IMEM_NOP       = 32'h0000_0013;
  localparam logic [31:0] IMEM_W0        = 32'h0010_0093;
  localparam logic [31:0] IMEM_W1        = 32'h0020_0113;
  localparam logic [31:0] IMEM_W2        = 32'h0020_80B3;
  localparam logic [31:0] IMEM_W3        = 32'hFFDF_F06F;
endpackage

// File: rtl/imem_rom.sv
// imem_rom: combinational word lookup; four-word boot loop followed by NOP fill.
module imem_rom
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic [AW-1:0] i_idx,
  output logic [31:0]   o_word
);
  always_comb
    o_word = i_idx == AW'(0) ? IMEM_W0 :
             i_idx == AW'(1) ? IMEM_W1 :
             i_idx == AW'(2) ? IMEM_W2 :
             i_idx == AW'(3) ? IMEM_W3 : IMEM_NOP;
endmodule

// File: rtl/imem.sv
// imem: read-only instruction memory with one-cycle registered output.
// Define IMEM_RANGE_CHECK_EN to return NOP outside the window instead of wrapping.
module imem
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE_ADDR,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [31:0] instr_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_next;
  logic [31:0]   r_instr;
  assign w_idx = AW'((addr - BASE_ADDR) >> 2);
  imem_rom #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_rom (
    .i_idx  (w_idx),
    .o_word (w_word)
  );
`ifdef IMEM_RANGE_CHECK_EN
  // addr below BASE_ADDR wraps to a huge offset, so one unsigned compare covers both ends
  always_comb
    w_next = (addr - BASE_ADDR) >= 32'(4 * DEPTH_WORDS) ? IMEM_NOP : w_word;
`else
  always_comb
    w_next = w_word;
`endif
  always_ff @(posedge clk)
    if (rst) r_instr <= IMEM_W0;
    else     r_instr <= w_next;
  assign instr_out = r_instr;
endmodule

// File: tb/tb_imem.sv
// tb_imem: directed and randomized checks of imem against an address-arithmetic reference model.
module tb_imem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] instr_out;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int          DEPTH = 256;
  logic [31:0] prog [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0020_80B3, 32'hFFDF_F06F};
  imem dut (.clk(clk), .rst(rst), .addr(addr), .instr_out(instr_out));
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [31:0] a);
    longint off;
    longint idx;
    off = longint'(a) - longint'(BASE);
`ifdef IMEM_RANGE_CHECK_EN
    if (off < 0 || off >= 4 * DEPTH) return 32'h0000_0013;
`endif
    if (off < 0) off = off + 64'd4294967296;
    idx = (off / 4) % DEPTH;
    return idx < 4 ? prog[idx] : 32'h0000_0013;
  endfunction
  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (instr_out === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, instr_out, exp);
    end
  endtask
  task automatic step(input logic [31:0] a, input logic r);
    @(negedge clk);
    addr = a;
    rst = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] a;
    logic        r;
    step('x, 1'b1);
    check("reset", 32'h0010_0093);
    step(32'h0100_0000, 1'b0); check("seq0", 32'h0010_0093);
    step(32'h0100_0004, 1'b0); check("seq1", 32'h0020_0113);
    step(32'h0100_0008, 1'b0); check("seq2", 32'h0020_80B3);
    step(32'h0100_000C, 1'b0); check("seq3", 32'hFFDF_F06F);
    step(32'h0100_000C, 1'b0); check("same_addr", 32'hFFDF_F06F);
    step(32'h0100_0006, 1'b0); check("misaligned", 32'h0020_0113);
    step(32'h0100_0010, 1'b0); check("nop_word4", 32'h0000_0013);
    step(32'h0100_03FC, 1'b0); check("last_word", 32'h0000_0013);
`ifdef IMEM_RANGE_CHECK_EN
    step(32'h0000_0000, 1'b0); check("below_range", 32'h0000_0013);
    step(32'h0100_0400, 1'b0); check("above_range", 32'h0000_0013);
`else
    step(32'h0000_0004, 1'b0); check("wrap_low", 32'h0020_0113);
    step(32'h0100_0408, 1'b0); check("wrap_high", 32'h0020_80B3);
`endif
    step(32'h0100_000C, 1'b1); check("reset_mid_read", 32'h0010_0093);
    step(32'h0100_0008, 1'b0); check("after_reset", 32'h0020_80B3);
    addr = 32'h0100_0004;
    @(negedge clk);
    check("hold_mid_cycle", 32'h0020_80B3);
    addr = 32'h0100_000C;
    #2;
    check("hold_late_change", 32'h0020_80B3);
    @(posedge clk);
    #1;
    check("update_next_edge", 32'hFFDF_F06F);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(3))
        0: a = $urandom;
        1: a = BASE + 32'($urandom_range(0, 31));
        2: a = BASE + 32'($urandom_range(0, 4 * DEPTH + 64)) - 32'd32;
        default: a = BASE + 32'(4 * DEPTH * $urandom_range(1, 3)) + 32'($urandom_range(0, 15));
      endcase
      r = ($urandom_range(15) == 0);
      step(a, r);
      check("random", r ? 32'h0010_0093 : model(a));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
